sm3_reg_file: RTL and testbench
===============================

# sm3_reg_file

AHB-slave register file for the SM3 hash accelerator. It holds the control, source-address, block-size and status registers, plus the 256-bit chaining value (H0..H7) that the host can preload and the hash core overwrites on completion. It drives the start strobe and job parameters into the SM3 datapath and raises the completion interrupt toward the host.

## Interface
- No parameters.
- AHB_HCLK  in  1  single clock; all state updates on its rising edge.
- AHB_HRESETN  in  1  reset, synchronous, active-high (1 = reset, despite the name suffix).
- AHB_HADDR  in  20  word index of the register.
- AHB_HSEL  in  1  slave select.
- AHB_HWRITE  in  1  1 = write, 0 = read.
- AHB_HWDATA  in  32  write data, sampled in the same cycle as the address.
- SET_STR  in  1  store strobe from the core; loads TEMP_RES into H0..H7 and marks the job done.
- TEMP_RES  in  256  result from the core; [255:224] maps to H0 and [31:0] maps to H7.
- ENABLE  out  1  start/busy level to the core (CTRL[0]).
- LAST_RES  out  256  current H0..H7, concatenated with H0 in the MSBs.
- SAR_ADDR  out  13  source address register.
- BSR  out  13  block-count register.
- CRYPT_INTR  out  1  interrupt, equal to STAT.DONE & CTRL.IE.
- AHB_HRDATA  out  32  read data.

## Operation
- Register map, indexed by AHB_HADDR. The full 20-bit compare applies.
  - 0 CTRL, R/W: bit0 START (drives ENABLE), bit1 IE. Bits 31:2 read as 0.
  - 1 SAR, R/W: bits 12:0. Upper bits are ignored on write and read as 0.
  - 2 BSR, R/W: bits 12:0. Upper bits are ignored on write and read as 0.
  - 3 STAT: bit0 DONE, write 1 to clear (writing 0 has no effect). bit1 is a read-only mirror of ENABLE.
  - 4..11 H0..H7, R/W 32-bit.
  - 12 ID, read-only constant 0x534D3300.
  - Index 13 and above: reads return 0; writes are ignored.
- Write condition: AHB_HSEL & AHB_HWRITE. The addressed register updates at the next rising edge using AHB_HWDATA from the same cycle. There are no wait states.
- Read: AHB_HRDATA is combinational from AHB_HADDR when AHB_HSEL & ~AHB_HWRITE. It is 0 otherwise.
- SET_STR high at an edge causes three updates:
  - H0..H7 <= TEMP_RES words.
  - DONE <= 1.
  - CTRL.START <= 0.
- Simultaneous events within the same cycle:
  - Host write vs SET_STR on the same H word: the host write wins. All other H words still load from TEMP_RES.
  - Host writes CTRL with bit0 = 1 while SET_STR is high: START = 1 (the write wins). IE always takes the written value.
  - Write-1-clear of DONE while SET_STR is high: DONE = 1 (the set wins).
- SAR_ADDR, BSR and LAST_RES are direct register outputs. They have no combinational path from the bus.

## Timing
- Reset values (synchronous, active-high):
  - CTRL = 0, SAR = 0, BSR = 0, DONE = 0.
  - ENABLE = 0, CRYPT_INTR = 0.
  - H0..H7 = SM3 IV: 7380166F 4914B2B9 172442D7 DA8A0600 A96F30BC 163138AA E38DEE4D B0FB0E4E.
- Reset has priority over SET_STR and over bus writes.
- A reset asserted mid-job aborts the job and restores the values above at that edge.
- Write to output latency is 1 edge. Example: write CTRL = 1 at edge N, and ENABLE = 1 after edge N.
- Read latency is 0 cycles. A read in the same cycle as a write returns the old value.
- SET_STR is sampled per edge. Holding it high reloads H from TEMP_RES every cycle and keeps DONE set.
- CRYPT_INTR goes high 1 edge after the SET_STR edge if IE = 1. It stays high until DONE is cleared or IE is written to 0.

## Test plan
- Reset behaviour: apply reset. Then read index 0..12 and check CTRL/SAR/BSR/STAT = 0, H0..H7 = SM3 IV, ID = 0x534D3300. ENABLE and CRYPT_INTR must be 0.
- Register write/readback: write SAR = 0xFFFFFFFF and BSR = 0x00001000. Read back SAR = 0x00001FFF and BSR = 0x00001000. SAR_ADDR must show 0x1FFF.
- Chaining value load and order: write H0..H7 = 0x00000001, 0x00000010, ..., 0x10000000. LAST_RES must equal the concatenation with H0 in the MSBs.
- Completion: write CTRL = 0x3, so ENABLE = 1. Pulse SET_STR for 1 cycle with TEMP_RES = 00000000_11111111_..._77777777. Then check:
  - ENABLE = 0.
  - H3 = 0x33333333.
  - STAT = 0x1.
  - CRYPT_INTR = 1.
  - Then write STAT = 1 and check CRYPT_INTR = 0.
- Collisions with SET_STR held high: write H2 = 0xFFFFFFFF and check H2 = 0xFFFFFFFF while the other H words equal the TEMP_RES words. Write STAT = 1 and check DONE stays 1.
- Decode: write index 13 and 0x80000, then read both and check 0. Write ID and check it still reads 0x534D3300. With AHB_HSEL = 0, AHB_HRDATA must be 0 and writes must be ignored.

Source files
------------

// File: rtl/sm3_reg_file.sv
// sm3_reg_file: AHB-slave register file for the SM3 hash accelerator.
// Holds control/status, job parameters and the H0..H7 chaining value.
module sm3_reg_file (
  input  logic         AHB_HCLK,
  input  logic         AHB_HRESETN,
  input  logic [19:0]  AHB_HADDR,
  input  logic         AHB_HSEL,
  input  logic         AHB_HWRITE,
  input  logic [31:0]  AHB_HWDATA,
  input  logic         SET_STR,
  input  logic [255:0] TEMP_RES,
  output logic         ENABLE,
  output logic [255:0] LAST_RES,
  output logic [12:0]  SAR_ADDR,
  output logic [12:0]  BSR,
  output logic         CRYPT_INTR,
  output logic [31:0]  AHB_HRDATA
);

  localparam logic [255:0] SM3_IV = {
    32'h7380166F, 32'h4914B2B9,
    32'h172442D7, 32'hDA8A0600,
    32'hA96F30BC, 32'h163138AA,
    32'hE38DEE4D, 32'hB0FB0E4E
  };

  localparam logic [31:0] ID_VAL = 32'h534D3300;

  localparam logic [19:0] A_CTRL = 20'd0;
  localparam logic [19:0] A_SAR  = 20'd1;
  localparam logic [19:0] A_BSR  = 20'd2;
  localparam logic [19:0] A_STAT = 20'd3;
  localparam logic [19:0] A_H0   = 20'd4;
  localparam logic [19:0] A_ID   = 20'd12;

  logic        start;
  logic        ie;
  logic        done;
  logic [12:0] sar;
  logic [12:0] bsr_q;
  logic [31:0] h [8];

  logic wr;
  logic rd;

  assign wr = AHB_HSEL & AHB_HWRITE;
  assign rd = AHB_HSEL & ~AHB_HWRITE;

  assign ENABLE     = start;
  assign CRYPT_INTR = done & ie;
  assign SAR_ADDR   = sar;
  assign BSR        = bsr_q;
  assign LAST_RES   = {h[0], h[1], h[2], h[3],
                       h[4], h[5], h[6], h[7]};

  // CTRL: a host write beats the core's start-clear
  always_ff @(posedge AHB_HCLK) begin
    if (AHB_HRESETN) begin
      start <= 1'b0;
      ie    <= 1'b0;
    end else if (wr && AHB_HADDR == A_CTRL) begin
      start <= AHB_HWDATA[0];
      ie    <= AHB_HWDATA[1];
    end else if (SET_STR) begin
      start <= 1'b0;
    end
  end

  // SAR and BSR job parameters
  always_ff @(posedge AHB_HCLK) begin
    if (AHB_HRESETN) begin
      sar   <= '0;
      bsr_q <= '0;
    end else begin
      if (wr && AHB_HADDR == A_SAR)
        sar <= AHB_HWDATA[12:0];
      if (wr && AHB_HADDR == A_BSR)
        bsr_q <= AHB_HWDATA[12:0];
    end
  end

  // DONE: set by core, w1c by host; set beats clear
  always_ff @(posedge AHB_HCLK) begin
    if (AHB_HRESETN)
      done <= 1'b0;
    else if (SET_STR)
      done <= 1'b1;
    else if (wr && AHB_HADDR == A_STAT
             && AHB_HWDATA[0])
      done <= 1'b0;
  end

  // H0..H7: host write to a word beats the core load
  always_ff @(posedge AHB_HCLK) begin
    for (int i = 0; i < 8; i++) begin
      if (AHB_HRESETN)
        h[i] <= SM3_IV[255-32*i -: 32];
      else if (wr && AHB_HADDR == A_H0 + 20'(i))
        h[i] <= AHB_HWDATA;
      else if (SET_STR)
        h[i] <= TEMP_RES[255-32*i -: 32];
    end
  end

  // Zero-wait combinational read mux
  always_comb begin
    AHB_HRDATA = '0;
    if (rd) begin
      case (AHB_HADDR)
        A_CTRL:  AHB_HRDATA = {30'd0, ie, start};
        A_SAR:   AHB_HRDATA = {19'd0, sar};
        A_BSR:   AHB_HRDATA = {19'd0, bsr_q};
        A_STAT:  AHB_HRDATA = {30'd0, start, done};
        20'd4:   AHB_HRDATA = h[0];
        20'd5:   AHB_HRDATA = h[1];
        20'd6:   AHB_HRDATA = h[2];
        20'd7:   AHB_HRDATA = h[3];
        20'd8:   AHB_HRDATA = h[4];
        20'd9:   AHB_HRDATA = h[5];
        20'd10:  AHB_HRDATA = h[6];
        20'd11:  AHB_HRDATA = h[7];
        A_ID:    AHB_HRDATA = ID_VAL;
        default: AHB_HRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sm3_reg_file.sv
// tb_sm3_reg_file: directed checks of the SM3 register file.
// Expected values are hand-computed constants.
module tb_sm3_reg_file;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [19:0]  haddr = '0;
  logic         hsel = 1'b0;
  logic         hwrite = 1'b0;
  logic [31:0]  hwdata = '0;
  logic         set_str = 1'b0;
  logic [255:0] temp_res = '0;
  logic         enable;
  logic [255:0] last_res;
  logic [12:0]  sar_addr;
  logic [12:0]  bsr;
  logic         crypt_intr;
  logic [31:0]  hrdata;

  int checks = 0;
  int errors = 0;

  logic [255:0] iv = {
    32'h7380166F, 32'h4914B2B9,
    32'h172442D7, 32'hDA8A0600,
    32'hA96F30BC, 32'h163138AA,
    32'hE38DEE4D, 32'hB0FB0E4E
  };

  sm3_reg_file dut (
    .AHB_HCLK    (clk),
    .AHB_HRESETN (rst),
    .AHB_HADDR   (haddr),
    .AHB_HSEL    (hsel),
    .AHB_HWRITE  (hwrite),
    .AHB_HWDATA  (hwdata),
    .SET_STR     (set_str),
    .TEMP_RES    (temp_res),
    .ENABLE      (enable),
    .LAST_RES    (last_res),
    .SAR_ADDR    (sar_addr),
    .BSR         (bsr),
    .CRYPT_INTR  (crypt_intr),
    .AHB_HRDATA  (hrdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h",
               tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [19:0] a,
                        input logic [31:0] d);
    @(negedge clk);
    haddr  = a;
    hwdata = d;
    hsel   = 1'b1;
    hwrite = 1'b1;
    @(posedge clk);
    #1;
    hsel   = 1'b0;
    hwrite = 1'b0;
  endtask

  task automatic bus_rd(input logic [19:0] a,
                        output logic [31:0] d);
    @(negedge clk);
    haddr  = a;
    hsel   = 1'b1;
    hwrite = 1'b0;
    #1;
    d    = hrdata;
    hsel = 1'b0;
  endtask

  logic [31:0]  rv;
  logic [31:0]  rst_exp [13];
  logic [255:0] exp_h;
  logic [255:0] tr2;

  initial begin
    // reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_enable", 256'(enable), 256'(0));
    check("rst_intr", 256'(crypt_intr), 256'(0));
    rst_exp[0] = 0; rst_exp[1] = 0;
    rst_exp[2] = 0; rst_exp[3] = 0;
    for (int i = 0; i < 8; i++)
      rst_exp[4+i] = iv[255-32*i -: 32];
    rst_exp[12] = 32'h534D3300;
    for (int i = 0; i < 13; i++) begin
      bus_rd(20'(i), rv);
      check($sformatf("rst_rd%0d", i),
            256'(rv), 256'(rst_exp[i]));
    end
    check("rst_last", last_res, iv);

    // SAR / BSR
    bus_wr(20'd1, 32'hFFFFFFFF);
    bus_wr(20'd2, 32'h00001000);
    bus_rd(20'd1, rv);
    check("sar_rd", 256'(rv), 256'h1FFF);
    bus_rd(20'd2, rv);
    check("bsr_rd", 256'(rv), 256'h1000);
    check("sar_port", 256'(sar_addr), 256'h1FFF);
    check("bsr_port", 256'(bsr), 256'h1000);

    // H order
    for (int i = 0; i < 8; i++)
      bus_wr(20'(4+i), 32'h1 << (4*i));
    check("h_order", last_res,
          {32'h00000001, 32'h00000010,
           32'h00000100, 32'h00001000,
           32'h00010000, 32'h00100000,
           32'h01000000, 32'h10000000});

    // completion
    bus_wr(20'd0, 32'h3);
    check("start_en", 256'(enable), 256'(1));
    bus_rd(20'd3, rv);
    check("stat_busy", 256'(rv), 256'h2);
    temp_res = {32'h00000000, 32'h11111111,
                32'h22222222, 32'h33333333,
                32'h44444444, 32'h55555555,
                32'h66666666, 32'h77777777};
    @(negedge clk);
    set_str = 1'b1;
    @(posedge clk);
    #1 set_str = 1'b0;
    check("done_en", 256'(enable), 256'(0));
    bus_rd(20'd7, rv);
    check("done_h3", 256'(rv), 256'h33333333);
    bus_rd(20'd3, rv);
    check("done_stat", 256'(rv), 256'h1);
    check("done_intr", 256'(crypt_intr), 256'(1));
    check("done_last", last_res, temp_res);
    bus_wr(20'd3, 32'h0);
    bus_rd(20'd3, rv);
    check("w0_stat", 256'(rv), 256'h1);
    bus_wr(20'd3, 32'h1);
    check("w1c_intr", 256'(crypt_intr), 256'(0));
    bus_rd(20'd3, rv);
    check("w1c_stat", 256'(rv), 256'h0);

    // collisions with SET_STR held high
    tr2 = {32'hA0000000, 32'hA0000001,
           32'hA0000002, 32'hA0000003,
           32'hA0000004, 32'hA0000005,
           32'hA0000006, 32'hA0000007};
    temp_res = tr2;
    @(negedge clk);
    set_str = 1'b1;
    bus_wr(20'd6, 32'hFFFFFFFF);
    exp_h = tr2;
    exp_h[191:160] = 32'hFFFFFFFF;
    check("col_last", last_res, exp_h);
    bus_rd(20'd6, rv);
    check("col_h2", 256'(rv), 256'hFFFFFFFF);
    bus_wr(20'd3, 32'h1);
    bus_rd(20'd3, rv);
    check("col_done", 256'(rv), 256'h1);
    bus_wr(20'd0, 32'h3);
    check("col_start", 256'(enable), 256'(1));
    @(posedge clk);
    #1;
    check("col_clr", 256'(enable), 256'(0));
    set_str = 1'b0;
    check("col_intr", 256'(crypt_intr), 256'(1));
    bus_wr(20'd0, 32'h0);
    check("ie_off", 256'(crypt_intr), 256'(0));

    // decode
    bus_wr(20'd13, 32'h12345678);
    bus_wr(20'h80000, 32'h12345678);
    bus_rd(20'd13, rv);
    check("dec_13", 256'(rv), 256'(0));
    bus_rd(20'h80000, rv);
    check("dec_hi", 256'(rv), 256'(0));
    bus_wr(20'h80001, 32'h0);
    bus_rd(20'd1, rv);
    check("dec_alias", 256'(rv), 256'h1FFF);
    bus_wr(20'd12, 32'h0);
    bus_rd(20'd12, rv);
    check("id_ro", 256'(rv), 256'h534D3300);
    @(negedge clk);
    haddr  = 20'd12;
    hsel   = 1'b0;
    hwrite = 1'b0;
    #1;
    check("nosel_rd", 256'(hrdata), 256'(0));
    @(negedge clk);
    haddr  = 20'd1;
    hwdata = 32'h0;
    hwrite = 1'b1;
    @(posedge clk);
    #1 hwrite = 1'b0;
    bus_rd(20'd1, rv);
    check("nosel_wr", 256'(rv), 256'h1FFF);

    // reset mid-job beats SET_STR and writes
    bus_wr(20'd0, 32'h3);
    @(negedge clk);
    set_str = 1'b1;
    rst     = 1'b1;
    haddr   = 20'd4;
    hwdata  = 32'hDEADBEEF;
    hsel    = 1'b1;
    hwrite  = 1'b1;
    @(posedge clk);
    #1;
    set_str = 1'b0;
    rst     = 1'b0;
    hsel    = 1'b0;
    hwrite  = 1'b0;
    check("mr_en", 256'(enable), 256'(0));
    check("mr_last", last_res, iv);
    bus_rd(20'd3, rv);
    check("mr_stat", 256'(rv), 256'(0));
    bus_rd(20'd1, rv);
    check("mr_sar", 256'(rv), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
